sensor_ctrl: RTL and testbench

Frame sequencer for the pixel array. It drives the ERASE → EXPOSE → CONVERT → READ phase control of all pixel rows and generates the 8-bit digital ramp counter broadcast to the rows during conversion. It then walks a row select through the array with a valid/ready handshake toward the readout logic. It sits between the top-level camera control (start, exposure time) and the `PIXEL_ROW` instances.

---
 rtl/sensor_ctrl.sv | 123 ++++++++++++
 tb/tb_sensor_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sensor_ctrl.sv
// sensor_ctrl: frame sequencer driving erase/expose/convert/read phases and the ramp counter.
// Optional feature: define SENSOR_CTRL_CONTINUOUS_EN to retrigger frames while start is held high.
module sensor_ctrl #(
    parameter int NUM_ROWS = 2,
    parameter int C_ERASE  = 5,
    parameter int ROW_W    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       expose_time,
    input  logic             read_ready,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic [7:0]       counter,
    output logic             read,
    output logic [ROW_W-1:0] row_sel,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = ($clog2(C_ERASE + 1) > 8) ? $clog2(C_ERASE + 1) : 8;

    typedef enum logic [2:0] {IDLE, ERASE, GAP, EXPOSE, CONVERT, READ} state_t;

    state_t          state_q, state_d, tgt_q, tgt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      e_q, e_d, counter_q, counter_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic            erase_q, expose_q, convert_q, read_q, busy_q, done_q, done_d;
    logic            trig;

`ifdef SENSOR_CTRL_CONTINUOUS_EN
    assign trig = start;
`else
    logic start_q;
    // start history for edge detection; reset high so a held start does not trigger
    always_ff @(posedge clk or posedge reset)
        if (reset) start_q <= 1'b1;
        else       start_q <= start;
    assign trig = start & ~start_q;
`endif

    // next-state, phase counter, row walk and frame-end pulse
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q + CW'(1);
        e_d     = e_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (trig) begin
                    state_d = ERASE;
                    e_d     = (expose_time == 8'd0) ? 8'd1 : expose_time;
                end
            end
            ERASE:   if (cnt_q == CW'(C_ERASE - 1)) begin state_d = GAP; tgt_d = EXPOSE; end
            EXPOSE:  if (cnt_q == CW'(e_q - 8'd1)) begin state_d = GAP; tgt_d = CONVERT; end
            CONVERT: if (cnt_q == CW'(255)) begin state_d = GAP; tgt_d = READ; end
            GAP: begin
                state_d = tgt_q;
                cnt_d   = '0;
                row_d   = '0;
            end
            READ: begin
                if (read_ready) begin
                    if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        counter_d = (state_d == CONVERT) ? cnt_d[7:0] : 8'd0;
    end

    // state and registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tgt_q     <= IDLE;
            cnt_q     <= '0;
            e_q       <= 8'd1;
            row_q     <= '0;
            counter_q <= 8'd0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            e_q       <= e_d;
            row_q     <= row_d;
            counter_q <= counter_d;
            erase_q   <= state_d == ERASE;
            expose_q  <= state_d == EXPOSE;
            convert_q <= state_d == CONVERT;
            read_q    <= state_d == READ;
            busy_q    <= state_d != IDLE;
            done_q    <= done_d;
        end
    end

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign counter    = counter_q;
    assign read       = read_q;
    assign row_sel    = row_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_sensor_ctrl.sv
// tb_sensor_ctrl: randomized self-checking bench for sensor_ctrl against a frame-timeline model.
module tb_sensor_ctrl;
    localparam int N  = 2;
    localparam int CE = 5;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, read_ready = 1'b0;
    logic [7:0] expose_time = 8'd0;
    logic       erase, expose, convert, read, busy, frame_done;
    logic [7:0] counter;
    logic [0:0] row_sel;

    sensor_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .expose_time(expose_time),
        .read_ready(read_ready), .erase(erase), .expose(expose), .convert(convert),
        .counter(counter), .read(read), .row_sel(row_sel), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // frame model: a frame is a timeline of offsets k from the trigger edge
    bit m_act, m_done, m_prev;
    int m_k, m_e, m_rows;
    int fc, done_at, busy_n, conv_n, exp_n, n_done;

    function automatic logic [31:0] exp_vec();
        int cs = CE + m_e + 3;
        logic er, ex, cv, rd;
        logic [7:0] ct, rw;
        er = m_act && m_k >= 1 && m_k <= CE;
        ex = m_act && m_k >= CE + 2 && m_k <= CE + 1 + m_e;
        cv = m_act && m_k >= cs && m_k < cs + 256;
        rd = m_act && m_k >= cs + 257;
        ct = cv ? 8'(m_k - cs) : 8'd0;
        rw = rd ? 8'(m_rows) : 8'd0;
        return {10'd0, m_act, m_done, er, ex, cv, rd, rw, ct};
    endfunction

    function automatic logic [31:0] obs();
        return {10'd0, busy, frame_done, erase, expose, convert, read, 7'd0, row_sel, counter};
    endfunction

    task automatic m_update(input logic s, input logic [7:0] et, input logic rr);
        bit nd = 0;
        bit tr;
`ifdef SENSOR_CTRL_CONTINUOUS_EN
        tr = s;
`else
        tr = s && !m_prev;
`endif
        if (m_act) begin
            if (m_k >= CE + m_e + 260 && rr) begin
                m_rows++;
                if (m_rows == N) begin m_act = 0; nd = 1; end
            end
            m_k++;
        end else if (tr) begin
            m_act = 1; m_k = 1; m_rows = 0;
            m_e = (et == 8'd0) ? 1 : int'(et);
            fc = 0; busy_n = 0; conv_n = 0; exp_n = 0; done_at = -1;
        end
        m_done = nd;
        m_prev = s;
    endtask

    task automatic step(input logic s, input logic [7:0] et, input logic rr);
        if (frame_done) begin done_at = fc; n_done++; end
        if (busy) busy_n++;
        if (convert) conv_n++;
        if (expose) exp_n++;
        check("cycle", obs(), exp_vec());
        start = s; expose_time = et; read_ready = rr;
        m_update(s, et, rr);
        fc++;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] et, input int stall_from, input int stall_len);
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, et, 1'b1);
        for (int i = 0; i < 400 && (m_act || m_done); i++)
            step(1'b0, 8'($urandom), !(m_act && m_k >= stall_from && m_k < stall_from + stall_len));
        step(1'b0, 8'd0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, lim, expf;
        m_act = 0; m_done = 0; m_prev = 1; m_e = 1; m_k = 0; m_rows = 0;
        fc = 0; done_at = -1; n_done = 0;
        repeat (3) @(negedge clk);
        check("reset", obs(), 32'd0);
        reset = 1'b0;
        step(1'b0, 8'd0, 1'b1);

        run_frame(8'd10, 0, 0);
        check("done_at", 32'(done_at), 32'd277);
        check("busy_n", 32'(busy_n), 32'd276);
        check("conv_n", 32'(conv_n), 32'd256);
        check("exp_n", 32'(exp_n), 32'd10);

        run_frame(8'd10, 275, 4);
        check("stall_done", 32'(done_at), 32'd281);

        run_frame(8'd0, 0, 0);
        check("e0_exp_n", 32'(exp_n), 32'd1);
        check("e0_done", 32'(done_at), 32'd268);

        n0 = n_done;
        step(1'b1, 8'd10, 1'b1);
        lim = 0;
        while (m_k != CE + 13 + 100 && lim < 400) begin step(1'b0, 8'd10, 1'b1); lim++; end
        check("conv_reach", 32'(lim < 400), 32'd1);
        #2 reset = 1'b1;
        #1 check("rst_async", obs(), 32'd0);
        #1 reset = 1'b0;
        m_act = 0; m_done = 0; m_prev = 1;
        start = 1'b0;
        m_update(1'b0, 8'd0, 1'b1);
        @(negedge clk);
        repeat (20) step(1'b0, 8'd0, 1'b1);
        check("rst_no_done", 32'(n_done - n0), 32'd0);
        run_frame(8'd10, 0, 0);
        check("post_rst_done", 32'(done_at), 32'd277);

        n0 = n_done;
        step(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 500; i++) step(1'b1, 8'd10, 1'b1);
        for (int i = 0; i < 400; i++) step(1'b0, 8'd10, 1'b1);
`ifdef SENSOR_CTRL_CONTINUOUS_EN
        expf = 2;
`else
        expf = 1;
`endif
        check("held_frames", 32'(n_done - n0), 32'(expf));

        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(1, 5)) step(1'b0, 8'($urandom), 1'($urandom));
            repeat ($urandom_range(1, 3)) step(1'b1, 8'($urandom_range(0, 15)), 1'b1);
            lim = 0;
            while ((m_act || m_done) && lim < 2000) begin
                step(1'b0, 8'($urandom), $urandom_range(0, 3) != 0);
                lim++;
            end
            check("rand_end", 32'(m_act), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
